// File: rtl/sha256_message_build_if.sv
// Stream bundle between a message source, the SHA-256 padding front end and the
// compression engine: 32-bit message words in, padded 512-bit blocks out.
interface sha256_message_build_if #(
  parameter int ID_W = 6
);
  // Both directions use valid/ready: a transfer happens on a rising clock edge
  // where valid, ready and the clock enable are all high; once raised, valid and
  // its payload stay put until that transfer completes.
  logic [31:0]     data_in;
  logic [2:0]      data_in_nbytes;
  logic [ID_W-1:0] data_in_id;
  logic            data_in_last;
  logic            data_in_valid;
  logic            data_in_ready;

  logic [511:0]    data_out;
  logic [ID_W-1:0] data_out_id;
  logic            data_out_last;
  logic            data_out_valid;
  logic            data_out_ready;

  modport master (
    output data_in, data_in_nbytes, data_in_id, data_in_last, data_in_valid,
    input  data_in_ready,
    input  data_out, data_out_id, data_out_last, data_out_valid,
    output data_out_ready
  );

  modport slave (
    input  data_in, data_in_nbytes, data_in_id, data_in_last, data_in_valid,
    output data_in_ready,
    output data_out, data_out_id, data_out_last, data_out_valid,
    input  data_out_ready
  );
endinterface

// File: rtl/sha256_message_build.sv
// SHA-256 message front end: packs 32-bit big-endian words into 512-bit blocks and
// applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit length), adding a block when needed.
module sha256_message_build #(
  parameter int ID_W = 6
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    sync_rst,
  sha256_message_build_if.slave   bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_EMIT      = 2'd1,
    S_EXTRA     = 2'd2,
    S_EMIT_LAST = 2'd3
  } state_t;

  state_t          state_q;
  logic [511:0]    blk_q;
  logic [3:0]      w_q;
  logic [60:0]     cnt_q;
  logic            first_q;
  logic [ID_W-1:0] id_q;
  logic            last_q;
  logic            extra_q;
  logic            p64_q;
  logic            in_rdy_q;
  logic            out_vld_q;

  logic            in_acc;
  logic            out_acc;
  logic [2:0]      nb;
  logic [60:0]     cnt_d;
  logic [6:0]      p;
  logic [31:0]     in_word;
  logic [511:0]    blk_d;
  int              widx;

  assign in_acc  = bus.data_in_valid & in_rdy_q & en;
  assign out_acc = out_vld_q & bus.data_out_ready & en;

  // Block image after accepting the current word; only consumed in FILL on in_acc.
  always_comb begin
    nb = 3'd4;
    if (bus.data_in_last && (bus.data_in_nbytes < 3'd4)) nb = bus.data_in_nbytes;
    cnt_d   = cnt_q + {58'd0, nb};
    p       = {1'b0, w_q, 2'b00} + {4'd0, nb};
    in_word = bus.data_in;
    if (bus.data_in_last) begin
      case (nb)
        3'd0:    in_word = 32'h8000_0000;
        3'd1:    in_word = {bus.data_in[31:24], 24'h80_0000};
        3'd2:    in_word = {bus.data_in[31:16], 16'h8000};
        3'd3:    in_word = {bus.data_in[31:8], 8'h80};
        default: in_word = bus.data_in;
      endcase
    end
    widx  = 32 * (15 - int'(w_q));
    blk_d = blk_q;
    blk_d[widx +: 32] = in_word;
    // A full last word pushes the 0x80 marker into the next word, which is still zero.
    if (bus.data_in_last && (nb == 3'd4) && (w_q != 4'd15)) blk_d[(widx - 32) +: 32] = 32'h8000_0000;
    if (bus.data_in_last && (p <= 7'd55)) blk_d[63:0] = {cnt_d, 3'b000};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_FILL;
      blk_q     <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      id_q      <= '0;
      last_q    <= 1'b0;
      extra_q   <= 1'b0;
      p64_q     <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (sync_rst) begin
      state_q   <= S_FILL;
      blk_q     <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      id_q      <= '0;
      last_q    <= 1'b0;
      extra_q   <= 1'b0;
      p64_q     <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_FILL: begin
          if (in_acc) begin
            blk_q <= blk_d;
            cnt_q <= cnt_d;
            if (first_q) begin
              id_q    <= bus.data_in_id;
              first_q <= 1'b0;
            end
            if (bus.data_in_last) begin
              state_q   <= S_EMIT;
              in_rdy_q  <= 1'b0;
              out_vld_q <= 1'b1;
              last_q    <= (p <= 7'd55);
              extra_q   <= (p > 7'd55);
              p64_q     <= (p == 7'd64);
            end else if (w_q == 4'd15) begin
              state_q   <= S_EMIT;
              in_rdy_q  <= 1'b0;
              out_vld_q <= 1'b1;
              last_q    <= 1'b0;
              extra_q   <= 1'b0;
            end else begin
              w_q <= w_q + 4'd1;
            end
          end else begin
            in_rdy_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (out_acc) begin
            out_vld_q <= 1'b0;
            if (extra_q) begin
              state_q <= S_EXTRA;
              extra_q <= 1'b0;
            end else begin
              state_q <= S_FILL;
              blk_q   <= '0;
              w_q     <= '0;
              last_q  <= 1'b0;
              if (last_q) begin
                cnt_q   <= '0;
                first_q <= 1'b1;
              end
            end
          end
        end
        S_EXTRA: begin
          // Length-only block; carries the 0x80 marker when the data filled the block exactly.
          blk_q     <= {(p64_q ? 32'h8000_0000 : 32'h0), 416'd0, cnt_q, 3'b000};
          last_q    <= 1'b1;
          out_vld_q <= 1'b1;
          state_q   <= S_EMIT_LAST;
        end
        S_EMIT_LAST: begin
          if (out_acc) begin
            state_q   <= S_FILL;
            out_vld_q <= 1'b0;
            blk_q     <= '0;
            w_q       <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign bus.data_in_ready  = in_rdy_q & en;
  assign bus.data_out_valid = out_vld_q & en;
  assign bus.data_out       = blk_q;
  assign bus.data_out_id    = id_q;
  assign bus.data_out_last  = last_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_sha256_message_build.sv
// Bench for sha256_message_build: byte-level FIPS 180-4 padding model feeding a
// scoreboard queue, randomized messages, enable and backpressure, plus directed cases.
module tb_sha256_message_build;
  localparam int ID_W = 6;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic       sync_rst;
  logic [1:0] dbg_state;

  sha256_message_build_if #(.ID_W(ID_W)) bus ();

  sha256_message_build #(.ID_W(ID_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .sync_rst    (sync_rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0]    exp_q[$];
  logic [ID_W-1:0] exp_id_q[$];
  logic            exp_last_q[$];
  logic [7:0]      msg_q[$];

  int rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
  bit en_rand  = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enable and downstream ready change just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      en = en_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
      case (rdy_mode)
        0:       bus.data_out_ready = 1'b1;
        1:       bus.data_out_ready = ($urandom_range(0, 2) != 0);
        default: bus.data_out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model ----------------
  task automatic push_expected(input logic [ID_W-1:0] id);
    logic [7:0]   pad[$];
    logic [63:0]  len;
    logic [511:0] blk;
    int           nblk;
    pad = msg_q;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    len = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(len[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = pad[64*b + i];
      exp_q.push_back(blk);
      exp_id_q.push_back(id);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [31:0] d, input logic [2:0] nb,
                            input logic [ID_W-1:0] id, input logic last);
    int cyc = 0;
    @(negedge clk);
    bus.data_in        = d;
    bus.data_in_nbytes = nb;
    bus.data_in_id     = id;
    bus.data_in_last   = last;
    bus.data_in_valid  = 1'b1;
    while (!bus.data_in_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.data_in_ready) chk("input_timeout", 512'(bus.data_in_ready), 512'(1));
    @(posedge clk);
  endtask

  task automatic end_msg();
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    bus.data_in_last  = 1'b0;
  endtask

  // Sends msg_q; extra_zero adds a trailing 0-byte last word, oversize uses nbytes 4..7.
  task automatic send_msg(input logic [ID_W-1:0] id, input bit extra_zero, input bit oversize);
    int              n;
    int              nw;
    logic [31:0]     d;
    logic [2:0]      nb;
    logic [ID_W-1:0] wid;
    logic            is_last;
    n = msg_q.size();
    push_expected(id);
    nw = (n == 0) ? 1 : (n + 3) / 4;
    if (extra_zero && n > 0 && (n % 4) == 0) nw++;
    for (int j = 0; j < nw; j++) begin
      d = $urandom();
      for (int b = 0; b < 4; b++) if (4*j + b < n) d[31 - 8*b -: 8] = msg_q[4*j + b];
      is_last = (j == nw - 1);
      if (is_last) begin
        nb = 3'(n - 4*j);
        if (nb == 3'd4 && oversize) nb = 3'($urandom_range(4, 7));
      end else begin
        nb = 3'($urandom_range(0, 7));
      end
      wid = (j == 0) ? id : ID_W'($urandom_range(0, 63));
      drive_word(d, nb, wid, is_last);
    end
    end_msg();
  endtask

  task automatic set_msg_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic set_msg_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 512'(exp_q.size()), 512'(0));
      exp_q.delete();
      exp_id_q.delete();
      exp_last_q.delete();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"},     bus.data_out,               512'(0));
    chk({tag, "_valid"},    512'(bus.data_out_valid),   512'(0));
    chk({tag, "_in_ready"}, 512'(bus.data_in_ready),    512'(0));
    chk({tag, "_last"},     512'(bus.data_out_last),    512'(0));
    chk({tag, "_id"},       512'(bus.data_out_id),      512'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (nrst && bus.data_out_valid && bus.data_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", 512'(bus.data_out_valid), 512'(0));
      end else begin
        chk("block_data", bus.data_out, exp_q.pop_front());
        chk("block_id",   512'(bus.data_out_id),   512'(exp_id_q.pop_front()));
        chk("block_last", 512'(bus.data_out_last), 512'(exp_last_q.pop_front()));
      end
    end
  end

  // ---------------- main sequence ----------------
  int           picks[8] = '{55, 56, 60, 63, 64, 119, 120, 128};
  logic [511:0] snap;
  int           cyc;
  int           len;

  initial begin
    nrst = 1'b0;
    sync_rst = 1'b0;
    en = 1'b1;
    bus.data_in = '0;
    bus.data_in_nbytes = '0;
    bus.data_in_id = '0;
    bus.data_in_last = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    nrst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 512'(bus.data_in_ready), 512'(1));

    // Directed: "abc", empty, 55/56/64 bytes, 64 bytes with trailing 0-byte word.
    set_msg_abc();       send_msg(6'd5, 1'b0, 1'b0); wait_drain(100);
    set_msg_random(0);   send_msg(6'd6, 1'b0, 1'b0); wait_drain(100);
    set_msg_random(55);  send_msg(6'd9, 1'b0, 1'b0); wait_drain(100);
    set_msg_random(56);  send_msg(6'd7, 1'b0, 1'b0); wait_drain(100);
    set_msg_random(64);  send_msg(6'd8, 1'b0, 1'b0); wait_drain(100);
    set_msg_random(64);  send_msg(6'd10, 1'b1, 1'b1); wait_drain(100);

    // Backpressure: block held for 5 cycles, then two back-to-back messages.
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    set_msg_abc();
    send_msg(6'd1, 1'b0, 1'b0);
    cyc = 0;
    while (!bus.data_out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_valid_seen", 512'(bus.data_out_valid), 512'(1));
    snap = bus.data_out;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_data_stable", bus.data_out, snap);
      chk("bp_valid_held",  512'(bus.data_out_valid), 512'(1));
      chk("bp_in_ready_low", 512'(bus.data_in_ready), 512'(0));
    end
    rdy_mode = 0;
    set_msg_random(20);
    send_msg(6'd2, 1'b0, 1'b0);
    wait_drain(200);

    // Asynchronous reset after 7 words of a 40-byte message.
    set_msg_random(40);
    for (int j = 0; j < 7; j++)
      drive_word({msg_q[4*j], msg_q[4*j+1], msg_q[4*j+2], msg_q[4*j+3]}, 3'd4, 6'd33, 1'b0);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    @(negedge clk);
    nrst = 1'b1;
    set_msg_abc();
    send_msg(6'd3, 1'b0, 1'b0);
    wait_drain(100);

    // Synchronous reset after 5 words.
    set_msg_random(40);
    for (int j = 0; j < 5; j++)
      drive_word({msg_q[4*j], msg_q[4*j+1], msg_q[4*j+2], msg_q[4*j+3]}, 3'd4, 6'd44, 1'b0);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    chk_outputs_zero("sync_rst");
    set_msg_random(56);
    send_msg(6'd4, 1'b0, 1'b0);
    wait_drain(100);

    // Randomized messages with random enable and backpressure.
    en_rand  = 1'b1;
    rdy_mode = 1;
    for (int m = 0; m < 30; m++) begin
      len = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 7)] : $urandom_range(0, 140);
      set_msg_random(len);
      send_msg(ID_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain(3000);
    en_rand  = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_message_build.md
Name: sha256_message_build

Overview:
- Front end of the SHA-256 hasher: takes a message as a stream of 32-bit big-endian words and emits padded 512-bit blocks.
- Its output port connects directly to the compression engine's data-in port (data, id, last, valid, ready).
- Performs FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit message bit length. When the length does not fit, an extra block is generated.
- A message ID is captured once per message and carried on every block of that message.

Parameters:
- ID_W, 6, width of the message ID.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  clock enable; when low, state holds and no handshakes complete
- sync_rst  in  1  synchronous local reset, same effect as nrst
- data_in  in  32  message word, first byte in bits [31:24]
- data_in_nbytes  in  3  valid bytes in a last word (0..4), MSB-aligned; ignored (treated as 4) when data_in_last=0
- data_in_id  in  ID_W  message ID, sampled on the first word of a message
- data_in_last  in  1  final word of the message
- data_in_valid  in  1  input valid
- data_in_ready  out  1  input ready (registered)
- data_out  out  512  padded block, word 0 in bits [511:480]
- data_out_id  out  ID_W  message ID
- data_out_last  out  1  final block of the message
- data_out_valid  out  1  block valid
- data_out_ready  in  1  downstream ready

Behaviour:
- Reset (nrst low or sync_rst high):
  - All outputs are 0; state is FILL; word index w=0; byte counter is 0; first-word flag is 1.
  - data_in_ready rises on the first enabled cycle after reset.
  - A reset mid-message discards the partial block and any pending output.
- States: FILL, EMIT, EXTRA, EMIT_LAST.
- Input handshake completes when data_in_valid && data_in_ready && en.
- Output handshake completes when data_out_valid && data_out_ready && en.
- data_out_valid is held, and data_out/id/last are held stable, until the output handshake. The valid/ready rules follow the compression engine's AXI-style protocol.
- FILL:
  - data_in_ready=1. Each accepted word is written to block word w, and w increments.
  - The byte counter adds 4, or nbytes on a last word. The counter is 61 bits and the bit length L = counter<<3. Overflow beyond 2^61 bytes wraps and is not flagged.
  - On the first word of a message, latch data_in_id.
  - Non-last word with w=15: go to EMIT with last=0. data_in_ready falls in the cycle after acceptance; data_out_valid rises in that same cycle.
  - Last word: let p = 4w + nbytes, in the range 0..64.
    - Byte p, if p<64, is set to 0x80. Partially valid bytes of the last word and all bytes above p are zeroed. Input junk bytes are masked.
    - If p<=55: bytes 56..63 = L big-endian; go to EMIT with last=1.
    - If p>=56: go to EMIT with last=0, then continue to EXTRA.
- EMIT:
  - On the output handshake: if the pending-extra flag is set, go to EXTRA. Otherwise go to FILL, clear the block, set w=0, and raise data_in_ready the next cycle.
  - After a last=1 block, also clear the byte counter and set the first-word flag.
- EXTRA (one cycle):
  - Build a block of zeros with L in bytes 56..63. If p was 64, byte 0 is also 0x80.
  - Go to EMIT_LAST with data_out_valid=1 and last=1.
- EMIT_LAST: on the output handshake, return to FILL exactly as EMIT does after a last block.
- Latency: the block is valid on the cycle after the accepting edge of its final word. One idle input cycle follows each emitted block, so throughput is at most 16 words per 18 cycles.
- en low:
  - Registers hold, no handshake completes, and data_in_ready/data_out_valid are driven 0.
  - Both are restored from state when en returns; the pending block is not lost.
- data_in_nbytes > 4 on a last word is treated as 4.

Test Plan:
- "abc": one word 0x61626300, nbytes=3, last, id=5.
  - Expect one block: word0 0x61626380, words 1..14 zero, word15 0x00000018, id=5, last=1.
  - Feeding it to the compression engine gives digest ba7816bf...f20015ad.
- Empty message: a single word with nbytes=0 and last.
  - Expect block word0 0x80000000, all else 0, last=1.
  - The engine returns e3b0c442...7852b855.
- 56-byte message (14 words, last nbytes=4):
  - Block 1: data, byte56 0x80, last=0.
  - Block 2: zeros, word15 0x000001C0, last=1.
- 64-byte message:
  - Block 1: data unchanged, last=0.
  - Block 2: word0 0x80000000, word15 0x00000200, last=1.
  - ID is identical on both blocks.
- Backpressure: hold data_out_ready=0 for 5 cycles while a block is valid.
  - data_out stays stable and data_in_ready stays 0.
  - After ready, the next message is accepted with no data loss. Run two back-to-back messages with ids 1 and 2 and check the ids.
- Reset: assert nrst low after 7 words of a message.
  - All outputs go to 0 immediately.
  - A subsequent "abc" message produces the correct single block with length 0x18 (counter cleared).
